// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// opcodes : shared types for the alu_mc multi-cycle ALU.
//   alu_mc_functions_t : 4-bit operation select. Codes 11..15 are undefined
//                        and pass ACC through with latency 1.
//   alu_mc_state_t     : controller states IDLE / RUN / DONE.
// -----------------------------------------------------------------------------
package opcodes;

   typedef enum logic [3:0] {
      FnMem  = 4'd0,
      FnADD  = 4'd1,
      FnSUB  = 4'd2,
      FnAND  = 4'd3,
      FnOR   = 4'd4,
      FnNOT  = 4'd5,
      FnLSL  = 4'd6,
      FnLSR  = 4'd7,
      FnLSLN = 4'd8,
      FnLSRN = 4'd9,
      FnMUL  = 4'd10
   } alu_mc_functions_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } alu_mc_state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// -----------------------------------------------------------------------------
// alu_mc_mul : radix-2 shift-add multiplier datapath, one partial product per
// step. After WIDTH steps {hi,lo} holds the full unsigned product.
//   clk_i, rst_i  : clock, async active-high reset
//   load_i        : capture a_i (multiplicand) and b_i (multiplier), clear hi
//   step_i        : perform one add/shift step
//   lo_d_o        : low half of the product as it will be after this step
//   hi_nz_d_o     : high half nonzero, as it will be after this step
// The look-ahead outputs let the controller register the final result on the
// same edge as the last step, avoiding an extra cycle.
// -----------------------------------------------------------------------------
module alu_mc_mul #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] lo_d_o,
   output logic             hi_nz_d_o
);

   logic [WIDTH-1:0] a_q, hi_q, lo_q;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic [WIDTH:0]   sum;

   // Add multiplicand when the current multiplier LSB is set, then shift the
   // whole {carry,hi,lo} right by one; the sum's LSB enters lo from the top.
   always_comb begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q  <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else if (load_i) begin
         a_q  <= a_i;
         hi_q <= '0;
         lo_q <= b_i;
      end else if (step_i) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign lo_d_o    = lo_d;
   assign hi_nz_d_o = |hi_d;

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : multi-cycle ALU with registered result and flags.
//   Clock, Reset : clock, async active-high reset
//   Start        : request, sampled only in IDLE
//   Function     : operation select (opcodes::alu_mc_functions_t)
//   ACC, Mem     : operands A and B; Mem[SHW-1:0] is N for LSLN/LSRN
//   Result       : registered result, held until the next accepted Start
//   Zflag/Nflag/Cflag : registered flags for Result
//   Busy         : high while in RUN
//   Done         : one-cycle pulse when Result/flags become valid
// Build option: define ALU_MC_MUL_EN to include the shift-add multiplier;
// otherwise FnMUL is treated as an undefined code (returns ACC, latency 1).
// -----------------------------------------------------------------------------
module alu_mc
   import opcodes::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  alu_mc_functions_t Function,
   input  logic [WIDTH-1:0]  ACC,
   input  logic [WIDTH-1:0]  Mem,
   output logic [WIDTH-1:0]  Result,
   output logic              Zflag,
   output logic              Nflag,
   output logic              Cflag,
   output logic              Busy,
   output logic              Done
);

   // Counter must hold WIDTH itself for the multiply.
   localparam int CW = SHW + 1;

   alu_mc_state_t     state_q;
   alu_mc_functions_t fn_q;
   logic [WIDTH-1:0]  sh_q, res_q;
   logic [CW-1:0]     cnt_q;
   logic              z_q, n_q, c_q, busy_q, done_q;

   logic [WIDTH-1:0]  sc_res, sh_d, run_res, fin_res;
   logic              sc_c, sh_c, run_c, fin_c;
   logic [WIDTH:0]    sum, diff;
   logic [SHW-1:0]    nsh;
   logic              multi;
   logic [WIDTH-1:0]  mul_lo;
   logic              mul_hi_nz;

   assign nsh = Mem[SHW-1:0];

   // Single-cycle result, computed straight from the inputs on the accept edge.
   always_comb begin
      sum    = {1'b0, ACC} + {1'b0, Mem};
      diff   = {1'b0, ACC} - {1'b0, Mem};
      sc_res = ACC;
      sc_c   = 1'b0;
      case (Function)
         FnMem:   sc_res = Mem;
         FnADD:   {sc_c, sc_res} = sum;
         FnSUB:   {sc_c, sc_res} = diff;   // diff[WIDTH] is the borrow
         FnAND:   sc_res = ACC & Mem;
         FnOR:    sc_res = ACC | Mem;
         FnNOT:   sc_res = ~ACC;
         FnLSL:   {sc_c, sc_res} = {ACC, 1'b0};
         FnLSR:   {sc_res, sc_c} = {1'b0, ACC};
         default: begin
            sc_res = ACC;                  // undefined, N=0 shifts, MUL when absent
            sc_c   = 1'b0;
         end
      endcase
   end

   // Decide whether the accepted op needs the RUN state.
   always_comb begin
      multi = ((Function == FnLSLN) || (Function == FnLSRN)) && (nsh != '0);
`ifdef ALU_MC_MUL_EN
      if (Function == FnMUL) multi = 1'b1;
`endif
   end

   // One-bit shift step; the bit leaving the register becomes the carry.
   always_comb begin
      if (fn_q == FnLSLN) begin
         sh_d = {sh_q[WIDTH-2:0], 1'b0};
         sh_c = sh_q[WIDTH-1];
      end else begin
         sh_d = {1'b0, sh_q[WIDTH-1:1]};
         sh_c = sh_q[0];
      end
   end

`ifdef ALU_MC_MUL_EN
   logic mul_load, mul_step;
   assign mul_load = (state_q == IDLE) && Start && (Function == FnMUL);
   assign mul_step = (state_q == RUN) && (fn_q == FnMUL);

   alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .load_i    (mul_load),
      .step_i    (mul_step),
      .a_i       (ACC),
      .b_i       (Mem),
      .lo_d_o    (mul_lo),
      .hi_nz_d_o (mul_hi_nz)
   );

   always_comb begin
      if (fn_q == FnMUL) begin
         run_res = mul_lo;
         run_c   = mul_hi_nz;
      end else begin
         run_res = sh_d;
         run_c   = sh_c;
      end
   end
`else
   assign mul_lo    = '0;
   assign mul_hi_nz = 1'b0;
   assign run_res   = sh_d;
   assign run_c     = sh_c;
`endif

   // Value loaded into Result on the transition into DONE.
   assign fin_res = (state_q == RUN) ? run_res : sc_res;
   assign fin_c   = (state_q == RUN) ? run_c   : sc_c;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         fn_q    <= FnMem;
         sh_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (Start) begin
                  fn_q <= Function;
                  sh_q <= ACC;
                  if (multi) begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                     cnt_q   <= (Function == FnMUL) ? CW'(WIDTH) : CW'(nsh);
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     res_q   <= fin_res;
                     z_q     <= (fin_res == '0);
                     n_q     <= fin_res[WIDTH-1];
                     c_q     <= fin_c;
                  end
               end
            end
            RUN: begin
               sh_q  <= sh_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  res_q   <= fin_res;
                  z_q     <= (fin_res == '0);
                  n_q     <= fin_res[WIDTH-1];
                  c_q     <= fin_c;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Result = res_q;
   assign Zflag  = z_q;
   assign Nflag  = n_q;
   assign Cflag  = c_q;
   assign Busy   = busy_q;
   assign Done   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (WIDTH=16), directed cases plus
// randomized operations against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_mc;
   import opcodes::*;

   localparam int W = 16;

   logic              Clock = 1'b0;
   logic              Reset = 1'b1;
   logic              Start = 1'b0;
   alu_mc_functions_t Function = FnMem;
   logic [W-1:0]      ACC = '0, Mem = '0;
   logic [W-1:0]      Result;
   logic              Zflag, Nflag, Cflag, Busy, Done;

   int vectors = 0;
   int miscompares = 0;

   alu_mc #(.WIDTH(W)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Function(Function),
      .ACC(ACC), .Mem(Mem), .Result(Result), .Zflag(Zflag), .Nflag(Nflag),
      .Cflag(Cflag), .Busy(Busy), .Done(Done)
   );

   always #5 Clock = ~Clock;

`ifdef ALU_MC_MUL_EN
   localparam logic [3:0] LONG_FN = 4'd10;
   localparam logic [W-1:0] LONG_B = 16'h0034;
   localparam int         LONG_LAT = 16;
`else
   localparam logic [3:0] LONG_FN = 4'd8;
   localparam logic [W-1:0] LONG_B = 16'h000F;
   localparam int         LONG_LAT = 15;
`endif
   localparam logic [W-1:0] LONG_A = 16'h0012;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: result, carry and number of RUN cycles from the operation rules.
   task automatic model(input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic c, output int lat);
      longint unsigned ua, ub, p;
      int n;
      ua = a; ub = b; n = b % W;
      res = a; c = 1'b0; lat = 0;
      case (fn)
         4'd0: res = b;
         4'd1: begin p = ua + ub; res = W'(p); c = (p >= 65536); end
         4'd2: begin res = W'(ua - ub); c = (ua < ub); end
         4'd3: res = a & b;
         4'd4: res = a | b;
         4'd5: res = ~a;
         4'd6: begin res = W'(ua * 2); c = a[W-1]; end
         4'd7: begin res = W'(ua / 2); c = a[0]; end
         4'd8: if (n != 0) begin
                  res = W'(ua << n); c = a[W-n]; lat = n;
               end
         4'd9: if (n != 0) begin
                  res = W'(ua >> n); c = a[n-1]; lat = n;
               end
`ifdef ALU_MC_MUL_EN
         4'd10: begin p = ua * ub; res = W'(p); c = (p >= 65536); lat = W; end
`endif
         default: ;
      endcase
   endtask

   task automatic do_op(input string tag, input logic [3:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      logic [W-1:0] er; logic ec; int el; int cyc; int busy;
      model(fn, a, b, er, ec, el);
      @(negedge Clock);
      Start = 1'b1; Function = alu_mc_functions_t'(fn); ACC = a; Mem = b;
      @(posedge Clock); #1;
      Start = 1'b0;
      cyc = 0; busy = 0;
      while (Done !== 1'b1 && cyc < 200) begin
         if (Busy === 1'b1) busy++;
         @(posedge Clock); #1;
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'(el));
      check({tag, " busy_cycles"}, 64'(busy), 64'(el));
      check({tag, " result"}, 64'(Result), 64'(er));
      check({tag, " zflag"}, 64'(Zflag), 64'(er == '0));
      check({tag, " nflag"}, 64'(Nflag), 64'(er[W-1]));
      check({tag, " cflag"}, 64'(Cflag), 64'(ec));
      check({tag, " busy_at_done"}, 64'(Busy), 64'(0));
      @(posedge Clock); #1;
      check({tag, " done_pulse"}, 64'(Done), 64'(0));
      check({tag, " result_hold"}, 64'(Result), 64'(er));
   endtask

   initial begin : main
      logic [W-1:0] er, rsnap; logic ec; int el; int dones;
      // reset state
      #12;
      check("rst result", 64'(Result), 64'(0));
      check("rst flags", 64'({Zflag, Nflag, Cflag, Busy, Done}), 64'(0));
      @(negedge Clock); Reset = 1'b0;

      // directed
      do_op("add_wrap", 4'd1, 16'hFFFF, 16'h0001);
      do_op("lsln4", 4'd8, 16'h0F0F, 16'h0004);
      do_op("lsrn0", 4'd9, 16'hA5A5, 16'h0010);
      do_op("lsrn15", 4'd9, 16'h8001, 16'h000F);
      do_op("sub_borrow", 4'd2, 16'h0003, 16'h0005);
      do_op("lsl_carry", 4'd6, 16'h8000, 16'h0000);
      do_op("undef", 4'd13, 16'hBEEF, 16'h1111);
      do_op("mul_a", 4'd10, 16'h0012, 16'h0034);
      do_op("mul_b", 4'd10, 16'h0100, 16'h0100);
      do_op("mul_off", 4'd10, 16'h1234, 16'h0002);

      // Start pulsed mid-operation must be ignored
      model(LONG_FN, LONG_A, LONG_B, er, ec, el);
      @(negedge Clock);
      Start = 1'b1; Function = alu_mc_functions_t'(LONG_FN); ACC = LONG_A; Mem = LONG_B;
      @(negedge Clock);
      Start = 1'b0;
      dones = 0; rsnap = '0;
      for (int i = 0; i < LONG_LAT + 6; i++) begin
         if (i == 3) begin
            Start = 1'b1; Function = FnSUB; ACC = 16'h0009; Mem = 16'h0002;
         end else Start = 1'b0;
         @(posedge Clock); #1;
         if (Done === 1'b1) begin dones++; rsnap = Result; end
         @(negedge Clock);
      end
      Start = 1'b0;
      check("midstart dones", 64'(dones), 64'(1));
      check("midstart result", 64'(rsnap), 64'(er));
      check("midstart hold", 64'(Result), 64'(er));

      // Reset in the middle of a long op
      @(negedge Clock);
      Start = 1'b1; Function = alu_mc_functions_t'(LONG_FN); ACC = LONG_A; Mem = LONG_B;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (5) @(posedge Clock);
      #2 Reset = 1'b1;
      #1;
      check("midrst result", 64'(Result), 64'(0));
      check("midrst flags", 64'({Zflag, Nflag, Cflag, Busy, Done}), 64'(0));
      @(negedge Clock); Reset = 1'b0;
      do_op("post_rst_add", 4'd1, 16'h0003, 16'h0004);

      // randomized
      for (int i = 0; i < 40; i++) begin
         do_op("rand", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount field width; derived from WIDTH and not overridden.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request; sampled only in IDLE.
REQ-006 Function  input  opcodes::alu_mc_functions_t  operation select.
REQ-007 ACC  input  WIDTH  operand A.
REQ-008 Mem  input  WIDTH  operand B; the low SHW bits give the shift amount for the N-bit shifts.
REQ-009 Result  output  WIDTH  registered result.
REQ-010 Zflag, Nflag, Cflag  output  1 each  registered flags for Result.
REQ-011 Busy  output  1  high while in RUN.
REQ-012 Done  output  1  one-cycle pulse when Result and the flags become valid.

Function
REQ-013 States SHALL be IDLE, RUN and DONE; after reset the block is in IDLE.
REQ-014 IDLE with Start=1 SHALL latch ACC, Mem and Function.
REQ-015 Single-cycle ops (FnMem, FnADD, FnSUB, FnAND, FnOR, FnNOT, FnLSL, FnLSR) SHALL go IDLE->DONE, so Done is asserted on the edge after Start (latency 1).
REQ-016 FnLSLN/FnLSRN SHALL shift one bit per cycle in RUN for N=Mem[SHW-1:0] cycles; Done follows the last shift; N=0 SHALL behave as a single-cycle op and return ACC.
REQ-017 FnMUL SHALL perform a shift-add multiply over exactly WIDTH RUN cycles; Result is the low WIDTH bits of the unsigned product.
REQ-018 DONE SHALL last one cycle and then return to IDLE; Result and the flags SHALL hold until the next accepted Start.
REQ-019 Start SHALL be ignored in RUN and DONE; operands are not re-latched.
REQ-020 Zflag SHALL be (Result==0), and Nflag SHALL be Result[WIDTH-1].
REQ-021 Cflag SHALL be set as follows:
- ADD: carry out.
- SUB: borrow, i.e. ACC<Mem unsigned.
- Shifts: the last bit shifted out, or 0 when N=0.
- MUL: 1 when the high half of the product is nonzero.
- All other ops: 0.
REQ-022 Any undefined Function code SHALL return ACC with latency 1.
REQ-023 All arithmetic SHALL be unsigned modulo 2^WIDTH.

Reset
REQ-024 Reset SHALL asynchronously force IDLE and clear Result, Zflag, Nflag, Cflag, Busy, Done and the internal counters to 0, including in the middle of an operation.
REQ-025 The first Start after Reset deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro ALU_MC_MUL_EN controls the multiplier.
- Defined: FnMUL behaves per REQ-017 and REQ-021.
- Undefined: the multiplier logic is absent and FnMUL is treated per REQ-022 (returns ACC, latency 1).

Structure
REQ-027 Package opcodes SHALL hold alu_mc_functions_t: the existing Fn codes plus FnLSLN, FnLSRN and FnMUL, with a state enum type.
REQ-028 The shift-add datapath SHALL be the sub-module alu_mc_mul, instantiated only under ALU_MC_MUL_EN.

Verification
REQ-029 ADD with ACC=16'hFFFF, Mem=16'h0001 -> Done 1 cycle after Start, Result=0, Z=1, C=1, N=0.
REQ-030 LSLN with ACC=16'h0F0F, Mem=4 -> Busy for 4 cycles, then Result=16'hF0F0, N=1, C=0.
REQ-031 MUL with ACC=16'h0012, Mem=16'h0034 -> Done after 16 RUN cycles, Result=16'h03A8, C=0; ACC=Mem=16'h0100 -> Result=0, Z=1, C=1.
REQ-032 Start pulsed with SUB operands in the middle of a MUL -> ignored, MUL result unchanged, exactly one Done.
REQ-033 Reset asserted at RUN cycle 5 of a MUL -> all outputs 0 at once, IDLE, then an ADD of 3+4 gives 7.
REQ-034 Build without ALU_MC_MUL_EN and issue FnMUL with ACC=16'h1234 -> Done after 1 cycle, Result=16'h1234.
